// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e    : operation code carried on md_op (0=MULT 1=MULTU 2=DIV 3=DIVU)
//   md_state_e : controller states (IDLE / RUN)
//   default busy-cycle counts for multiply and divide
//   is_div_op  : true for DIV/DIVU (selects the longer busy time)
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Both divide codes have bit 1 set.
    function automatic logic is_div_op(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit multiply/divide datapath.
//   op     in  md_op_e  operation select
//   a, b   in  32       rs / rt operands
//   res_hi out 32       product high word, or remainder
//   res_lo out 32       product low word, or quotient
//   div0   out 1        divisor is zero (divide result must not be committed)
module md_calc
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    // Operands widened to 64 bits so 0x80000000 / -1 yields +2^31 without
    // overflow; its low word is the architecturally expected 0x80000000.
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sb_safe;
    logic        [31:0] ub_safe;

    assign sa   = {{32{a[31]}}, a};
    assign sb   = {{32{b[31]}}, b};
    assign div0 = (b == 32'd0);

    // A zero divisor is replaced by 1 so the simulated datapath never goes X;
    // the result is discarded via div0 anyway.
    assign sb_safe = div0 ? 64'sd1 : sb;
    assign ub_safe = div0 ? 32'd1  : b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = sa * sb;
            MD_MULTU: {res_hi, res_lo} = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                // SystemVerilog / truncates toward zero and % follows the
                // sign of the dividend, matching the ISA.
                res_lo = 32'(sa / sb_safe);
                res_hi = 32'(sa % sb_safe);
            end
            MD_DIVU: begin
                res_lo = a / ub_safe;
                res_hi = a % ub_safe;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
//   clk, reset  synchronous active-high reset
//   start       1-cycle launch pulse for md_op on src_a/src_b
//   md_op       0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a/src_b operands (src_a is also the MTHI/MTLO data)
//   wr_hi/wr_lo MTHI / MTLO write strobes (honoured only when idle and not starting)
//   busy        operation in flight (registered)
//   busy_any    start | busy, combinational, for the hazard unit
//   hi, lo      architectural HI/LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    output logic        busy,
    output logic        busy_any,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    logic        pend_div0_reg, pend_div0_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    md_op_e      op;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_div0;

    assign op = md_op_e'(md_op);

    md_calc u_calc (
        .op     (op),
        .a      (src_a),
        .b      (src_b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (res_div0)
    );

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_hi_next   = pend_hi_reg;
        pend_lo_next   = pend_lo_reg;
        pend_div0_next = pend_div0_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    // Result is captured at launch; the busy period only
                    // models the latency of the real iterative unit.
                    pend_hi_next   = res_hi;
                    pend_lo_next   = res_lo;
                    pend_div0_next = is_div_op(op) && res_div0;
                    cnt_next       = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_next     = ST_RUN;
                end else begin
                    if (wr_hi) hi_next = src_a;
                    if (wr_lo) lo_next = src_a;
                end
            end
            ST_RUN: begin
                // start and wr_* are ignored here; the pipeline stalls them.
                if (cnt_reg == CNT_W'(1)) begin
                    if (!pend_div0_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pend_hi_reg   <= '0;
            pend_lo_reg   <= '0;
            pend_div0_reg <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_hi_reg   <= pend_hi_next;
            pend_lo_reg   <= pend_lo_next;
            pend_div0_reg <= pend_div0_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
        end
    end

    assign busy     = (state_reg == ST_RUN);
    assign busy_any = start | busy;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: hand-computed HI/LO results, busy lengths,
// division-by-zero, signed overflow, MTHI/MTLO interaction and mid-op reset.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_hi;
    logic        wr_lo;
    logic        busy;
    logic        busy_any;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .busy     (busy),
        .busy_any (busy_any),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The pipeline never issues start while busy; flag it if it happens.
    always @(negedge clk) begin
        if (start === 1'b1) check("no_start_while_busy", {63'd0, busy}, 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle (optionally with MTHI data), checking the
    // combinational busy_any before the launch edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic with_wr_hi);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        wr_hi = with_wr_hi;
        #1;
        check("busy_any_on_start", {63'd0, busy_any}, 64'd1);
        tick();
        start = 1'b0;
        wr_hi = 1'b0;
    endtask

    // Count busy cycles until completion (bounded); optionally pulse MTLO
    // during the second busy cycle.
    task automatic wait_done(input string tag, input int exp_n, input logic inject_mtlo);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (inject_mtlo && n == 1) begin
                wr_lo = 1'b1;
                src_a = 32'h0000AAAA;
            end else begin
                wr_lo = 1'b0;
            end
            n++;
            tick();
        end
        wr_lo = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
        $display("%s: busy %0d cycles -> hi=0x%08h lo=0x%08h", tag, n, hi, lo);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 2'd0;
        src_a = '0;
        src_b = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_busy_any", {63'd0, busy_any}, 64'd0);
        expect_hilo("reset", 32'd0, 32'd0);

        // MULT -3 * 5 = -15
        launch(2'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        check("mult_hi_not_early", {32'd0, hi}, 64'd0);
        wait_done("mult", 5, 1'b0);
        expect_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);

        // MULTU 0xFFFFFFFF * 2
        launch(2'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_done("multu", 5, 1'b0);
        expect_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

        // DIV -7 / 2 = -3 rem -1
        launch(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_done("div", 10, 1'b0);
        expect_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // MTHI then DIVU by zero: HI/LO untouched
        do_reset();
        wr_hi = 1'b1;
        src_a = 32'h12345678;
        tick();
        wr_hi = 1'b0;
        expect_hilo("mthi", 32'h12345678, 32'd0);
        launch(2'd3, 32'd7, 32'd0, 1'b0);
        wait_done("divu_by0", 10, 1'b0);
        expect_hilo("divu_by0", 32'h12345678, 32'd0);

        // MTHI and MTLO together
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        src_a = 32'hCAFEF00D;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        expect_hilo("mthi_mtlo", 32'hCAFEF00D, 32'hCAFEF00D);

        // DIV signed overflow
        launch(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done("div_ovf", 10, 1'b0);
        expect_hilo("div_ovf", 32'd0, 32'h80000000);
        check("div_ovf_no_x", {62'd0, $isunknown(hi), $isunknown(lo)}, 64'd0);

        // MTLO while busy with MULT 3*4 is ignored
        launch(2'd0, 32'd3, 32'd4, 1'b0);
        wait_done("mult_mtlo_busy", 5, 1'b1);
        expect_hilo("mult_mtlo_busy", 32'd0, 32'd12);

        // start + wr_hi same cycle: start wins
        wr_hi = 1'b1;
        src_a = 32'h00005555;
        tick();
        wr_hi = 1'b0;
        check("mthi_5555", {32'd0, hi}, 64'h5555);
        launch(2'd1, 32'd2, 32'd3, 1'b1);
        check("start_wr_hi_ignored", {32'd0, hi}, 64'h5555);
        wait_done("multu_start_wr", 5, 1'b0);
        expect_hilo("multu_start_wr", 32'd0, 32'd6);

        // DIV 100/7 aborted by reset at busy cycle 4
        launch(2'd2, 32'd100, 32'd7, 1'b0);
        tick();
        tick();
        tick();
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        expect_hilo("abort", 32'd0, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_busy_later", {63'd0, busy}, 64'd0);
        expect_hilo("abort_no_wb", 32'd0, 32'd0);
        $display("abort: reset mid-DIV -> hi=0x%08h lo=0x%08h", hi, lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
